// File: rtl/kb_event_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kb_event_pkg
// Purpose  : Shared types and constants for the keyboard event queue.
//            Contents:
//              - the scan-code parser state encoding
//              - the set-2 prefix bytes (extended, break, pause)
//              - the fake-shift codes
//              - the bit positions of the fields in a one-byte key event
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package kb_event_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_SKIP    = 3'd4
  } parse_state_t;

  localparam logic [7:0] PFX_EXT      = 8'hE0;
  localparam logic [7:0] PFX_BRK      = 8'hF0;
  localparam logic [7:0] PFX_PAUSE    = 8'hE1;
  localparam logic [2:0] PAUSE_SKIP   = 3'd7;
  localparam logic [7:0] FAKE_SHIFT_L = 8'h12;
  localparam logic [7:0] FAKE_SHIFT_R = 8'h59;

  // Event byte layout: release flag on top, 7-bit key code below.
  localparam int EV_REL_BIT  = 7;
  localparam int EV_CODE_MSB = 6;
  localparam int EV_CODE_LSB = 0;

  // Extended sequences wrap some keys in synthetic shift make/break codes.
  // Those codes must never reach the CPU.
  function automatic logic is_fake_shift(input logic [7:0] code);
    return (code == FAKE_SHIFT_L) || (code == FAKE_SHIFT_R);
  endfunction

endpackage
`default_nettype wire

// File: rtl/kb_event_fifo.sv
`default_nettype none
// ============================================================================
// Module   : kb_event_fifo
// Purpose  : DEPTH x 8 synchronous FIFO for key events. A push and a pop in
//            the same cycle are both honoured, even when the FIFO is full.
//            A pop while empty is ignored.
// Ports    :
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   push_i   in   write data_i this cycle (dropped if full without a pop)
//   data_i   in   event byte to write
//   pop_i    in   advance the read pointer (ignored if empty)
//   head_o   out  oldest entry, 0 when empty (combinational)
//   count_o  out  entries held, 0..DEPTH
//   full_o   out  count_o == DEPTH
//   empty_o  out  count_o == 0
// Revision : 1.0 - initial release
// ============================================================================
module kb_event_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);

  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
    // naturally.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; an entry is only visible once it has been
  // written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/kb_event_queue.sv
`default_nettype none
// ============================================================================
// Module   : kb_event_queue
// Purpose  : Parses PS/2 set-2 scan bytes into one-byte key events and
//            queues them for the CPU.
//            Event byte: bit 7 = release, bits 6:0 = scan_code[6:0].
//            A rising edge of ack pops the head entry.
//            Optional macro KB_REPEAT_FILTER_EN: tracks a held-key vector
//            and discards repeated presses of a key that is already held.
// Ports    :
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   scan_code  in   raw byte from the PS/2 receiver
//   scan_valid in   one-cycle strobe qualifying scan_code
//   ack        in   CPU read of the KEYBOARD address (level)
//   dout       out  {non-empty, head event}; 9'h000 when empty
//   count      out  entries held
//   overflow   out  sticky: an event was dropped because the FIFO was full
// Revision : 1.0 - initial release
// ============================================================================
module kb_event_queue
  import kb_event_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             scan_code,
  input  logic                   scan_valid,
  input  logic                   ack,
  output logic [8:0]             dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  parse_state_t state_q, state_d;
  logic [2:0]   skip_q, skip_d;
  logic         ack_q;
  logic         overflow_q;
  logic         ev_push;
  logic         ev_rel;
  logic [7:0]   ev_byte;
  logic         fifo_push;
  logic         pop;
  logic [7:0]   head;
  logic         full;
  logic         empty;

  // Parser next-state logic. Codes with bit 7 set have no 7-bit key
  // encoding, so they are dropped wherever an event would be made.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    ev_push = 1'b0;
    ev_rel  = 1'b0;
    if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code == PFX_EXT) begin
            state_d = ST_EXT;
          end else if (scan_code == PFX_BRK) begin
            state_d = ST_BRK;
          end else if (scan_code == PFX_PAUSE) begin
            state_d = ST_SKIP;
            skip_d  = PAUSE_SKIP;
          end else if (!scan_code[7]) begin
            ev_push = 1'b1;
          end
        end
        ST_EXT: begin
          if (scan_code == PFX_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            state_d = ST_IDLE;
            ev_push = !scan_code[7] && !is_fake_shift(scan_code);
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          ev_push = !scan_code[7];
          ev_rel  = 1'b1;
        end
        ST_EXT_BRK: begin
          state_d = ST_IDLE;
          ev_push = !scan_code[7] && !is_fake_shift(scan_code);
          ev_rel  = 1'b1;
        end
        ST_SKIP: begin
          // The pause sequence is a fixed length. The byte that takes the
          // counter to zero is the last one swallowed.
          skip_d = skip_q - 1'b1;
          if (skip_q == 3'd1) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ev_byte                          = 8'h00;
    ev_byte[EV_REL_BIT]              = ev_rel;
    ev_byte[EV_CODE_MSB:EV_CODE_LSB] = scan_code[6:0];
  end

`ifdef KB_REPEAT_FILTER_EN
  logic [127:0] held_q, held_d;
  logic         press_dup;

  assign press_dup = ev_push & ~ev_rel & held_q[scan_code[6:0]];
  assign fifo_push = ev_push & ~press_dup;

  // The held state follows the key itself. It is updated even when the
  // FIFO later drops the event.
  always_comb begin
    held_d = held_q;
    if (ev_push) held_d[scan_code[6:0]] = ~ev_rel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) held_q <= '0;
    else     held_q <= held_d;
  end
`else
  assign fifo_push = ev_push;
`endif

  // Only the first cycle of an ack read pops. A CPU that holds the address
  // across several cycles still consumes just one entry.
  assign pop = ack & ~ack_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      skip_q     <= '0;
      ack_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      ack_q      <= ack;
      // A full FIFO with a concurrent pop still accepts, so that case is
      // not an overflow.
      overflow_q <= overflow_q | (fifo_push & full & ~pop);
    end
  end

  kb_event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (ev_byte),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign dout     = {~empty, head};
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_kb_event_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_kb_event_queue
// Purpose  : Directed self-checking bench for kb_event_queue (DEPTH = 8).
//            The same bench serves builds with and without the macro
//            KB_REPEAT_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kb_event_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic       ack = 1'b0;
  logic [8:0] dout;
  logic [3:0] count;
  logic       overflow;

  int tests = 0;
  int fails = 0;

  kb_event_queue #(.DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .ack        (ack),
    .dout       (dout),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge and are sampled on the next rising
  // edge. Results are checked on the falling edge that follows.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scan_code  = b;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

`ifdef KB_REPEAT_FILTER_EN
  localparam int NREP = 2;
  logic [8:0] rep_exp [4] = '{9'h11D, 9'h19D, 9'h000, 9'h000};
`else
  localparam int NREP = 4;
  logic [8:0] rep_exp [4] = '{9'h11D, 9'h11D, 9'h11D, 9'h19D};
`endif

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_dout", dout, 9'h000);
    chk("reset_count", {5'd0, count}, 9'd0);
    chk("reset_ovf", {8'd0, overflow}, 9'd0);
    rst = 1'b0;

    // Press and release of 1C.
    send(8'h1C); send(8'hF0); send(8'h1C);
    chk("mk_brk_count", {5'd0, count}, 9'd2);
    chk("mk_brk_head0", dout, 9'h11C);
    pulse_ack();
    chk("mk_brk_head1", dout, 9'h19C);
    pulse_ack();
    chk("mk_brk_empty", dout, 9'h000);
    chk("mk_brk_cnt0", {5'd0, count}, 9'd0);

    // Extended keys and fake shifts.
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h12);
    send(8'hE0); send(8'hF0); send(8'h59);
    chk("ext_count", {5'd0, count}, 9'd2);
    chk("ext_head0", dout, 9'h175);
    pulse_ack();
    chk("ext_head1", dout, 9'h1F5);
    pulse_ack();
    chk("ext_cnt0", {5'd0, count}, 9'd0);

    // Pause sequence emits nothing; the key that follows is parsed.
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk("pause_none", {5'd0, count}, 9'd0);
    send(8'h29);
    chk("pause_cnt", {5'd0, count}, 9'd1);
    chk("pause_head", dout, 9'h129);
    pulse_ack();

    // Typematic repeat.
    send(8'h1D); send(8'h1D); send(8'h1D); send(8'hF0); send(8'h1D);
    chk("rep_count", {5'd0, count}, 9'(NREP));
    for (int i = 0; i < NREP; i++) begin
      chk($sformatf("rep_head%0d", i), dout, rep_exp[i]);
      pulse_ack();
    end
    chk("rep_empty", dout, 9'h000);

    // Pop while empty is ignored.
    pulse_ack();
    chk("empty_pop_cnt", {5'd0, count}, 9'd0);

    // Fill, overflow, then push coinciding with a pop while full.
    for (int i = 1; i <= 8; i++) send(8'(i));
    chk("full_cnt", {5'd0, count}, 9'd8);
    chk("full_no_ovf", {8'd0, overflow}, 9'd0);
    send(8'h09);
    chk("ovf_cnt", {5'd0, count}, 9'd8);
    chk("ovf_set", {8'd0, overflow}, 9'd1);
    chk("ovf_head", dout, 9'h101);
    @(negedge clk);
    scan_code  = 8'h0A;
    scan_valid = 1'b1;
    ack        = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
    ack        = 1'b0;
    chk("pushpop_cnt", {5'd0, count}, 9'd8);
    chk("pushpop_head", dout, 9'h102);
    repeat (7) pulse_ack();
    chk("wrap_head", dout, 9'h10A);
    pulse_ack();
    chk("drain_cnt", {5'd0, count}, 9'd0);
    chk("ovf_sticky", {8'd0, overflow}, 9'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ovf_async_clr", {8'd0, overflow}, 9'd0);
    @(negedge clk);
    rst = 1'b0;

    // ack held high pops exactly once.
    send(8'h21); send(8'h22); send(8'h23);
    chk("hold_pre", {5'd0, count}, 9'd3);
    @(negedge clk);
    ack = 1'b1;
    repeat (5) @(negedge clk);
    chk("hold_cnt", {5'd0, count}, 9'd2);
    chk("hold_head", dout, 9'h122);
    ack = 1'b0;
    pulse_ack();
    chk("hold_next", dout, 9'h123);
    pulse_ack();

    // Reset mid-sequence returns the parser to IDLE.
    send(8'hF0);
    do_reset();
    send(8'h1C);
    chk("rst_brk_head", dout, 9'h11C);
    send(8'hE0);
    do_reset();
    send(8'h12);
    chk("rst_ext_cnt", {5'd0, count}, 9'd1);
    chk("rst_ext_head", dout, 9'h112);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
